// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I I/S/B instruction encoder.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        FMT_I   = 2'b00,
        FMT_S   = 2'b01,
        FMT_B   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_e;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_WRITE
    } state_e;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM13_MAX = 32'sd4094;

    typedef struct packed {
        fmt_e        fmt;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    // B offsets must also be even: bit 0 has no slot in the encoding.
    function automatic logic imm_out_of_range(fmt_e fmt, logic [31:0] imm);
        logic signed [31:0] s;
        logic               bad;
        s   = $signed(imm);
        bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: bad = (s < IMM12_MIN) || (s > IMM12_MAX);
            FMT_B:        bad = (s < IMM13_MIN) || (s > IMM13_MAX) || imm[0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_fmt;
    logic [2:0]           in_funct3;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [31:0]          in_imm;
    logic                 flush;
    logic                 mem_we;
    logic                 mem_ready;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm, flush, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, err, err_cnt
    );

    modport slave (
        input  in_valid, in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm, flush, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, err, err_cnt
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: captured fields -> RV32I I/S/B word plus immediate range-fail flag.
// Range checking is compiled in only when IMM_RANGE_CHECK_EN is defined.
module instr_pack
    import instr_enc_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        range_fail
);

    always_comb begin
        word = '0;
        case (f.fmt)
            FMT_I:   word = {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_I};
            FMT_S:   word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], OP_S};
            FMT_B:   word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                             f.imm[4:1], f.imm[11], OP_B};
            default: word = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    assign range_fail = imm_out_of_range(f.fmt, f.imm);
`else
    // Without checking, the upper immediate bits are simply truncated away.
    logic unused_imm_hi;
    assign unused_imm_hi = ^f.imm[31:13];
    assign range_fail    = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: accept -> encode (1 cycle) -> write until mem_ready; err/mem_we one cycle after accept.
// in_ready only in IDLE, so memory backpressure stalls intake. IMM_RANGE_CHECK_EN enables immediate rejection.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus
);

    state_e                 state_q, state_d;
    fields_t                fields_q, fields_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            addr_q, addr_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   in_ready_q, in_ready_d;

    logic [31:0]            packed_word;
    logic                   range_fail;
    logic                   reject;

    instr_pack u_pack (
        .f          (fields_q),
        .word       (packed_word),
        .range_fail (range_fail)
    );

    assign reject = (fields_q.fmt == FMT_RSV) || range_fail;

    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        we_d      = we_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (bus.flush) begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
            addr_d  = BASE_ADDR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        fields_d.fmt    = fmt_e'(bus.in_fmt);
                        fields_d.funct3 = bus.in_funct3;
                        fields_d.rd     = bus.in_rd;
                        fields_d.rs1    = bus.in_rs1;
                        fields_d.rs2    = bus.in_rs2;
                        fields_d.imm    = bus.in_imm;
                        state_d         = ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (reject) begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        state_d = ST_IDLE;
                    end else begin
                        wdata_d = packed_word;
                        we_d    = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ready) begin
                        we_d    = 1'b0;
                        addr_d  = addr_q + 32'd4;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Registered so mem_ready never reaches in_ready combinationally.
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fields_q   <= '0;
            wdata_q    <= '0;
            addr_q     <= BASE_ADDR;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fields_q   <= fields_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, randomized bundles against a field-level model, flush/reset sequences.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFFC;
    localparam int          CW   = 8;

    logic clk;
    logic reset;

    instr_encoder_if #(.ERR_CNT_W(CW)) bus ();

    instr_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_addr;
    int          m_errcnt;
    logic [31:0] m_word;

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        rej;
        logic [31:0] word;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Field-level reference: plain shifts/masks of the immediate per format.
    function automatic void ref_encode(input logic [1:0] fmt, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] imm,
                                       output logic rej, output logic [31:0] word);
        int signed s;
        s    = int'(imm);
        rej  = (fmt == 2'b11);
        word = 32'h0;
        case (fmt)
            2'b00: word = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                        | (32'(rd) << 7) | 32'h13;
            2'b01: word = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                        | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            2'b10: word = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                        | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                        | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            default: word = 32'h0;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        if (fmt == 2'b00 || fmt == 2'b01)
            rej = rej || (s < -2048) || (s > 2047);
        if (fmt == 2'b10)
            rej = rej || (s < -4096) || (s > 4094) || ((s % 2) != 0);
`endif
    endfunction

    // Present one bundle, check accept and the cycle after (err or mem_we).
    task automatic issue(input logic [1:0] fmt, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic exp_rej, input logic [31:0] exp_word);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_fmt = fmt; bus.in_funct3 = f3; bus.in_rd = rd;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_fmt    = 2'($urandom);
        bus.in_funct3 = 3'($urandom);
        bus.in_rd     = 5'($urandom);
        bus.in_rs1    = 5'($urandom);
        bus.in_rs2    = 5'($urandom);
        bus.in_imm    = $urandom;
        chk("in_ready_encode", 32'(bus.in_ready), 32'd0);
        chk("mem_we_encode", 32'(bus.mem_we), 32'd0);
        chk("err_pulse_width", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        chk("err", 32'(bus.err), 32'(exp_rej));
        chk("mem_we", 32'(bus.mem_we), 32'(!exp_rej));
        if (exp_rej) begin
            if (m_errcnt < 255) m_errcnt++;
            chk("err_cnt", 32'(bus.err_cnt), 32'(m_errcnt));
            chk("addr_after_reject", bus.mem_addr, m_addr);
            chk("in_ready_after_reject", 32'(bus.in_ready), 32'd1);
        end else begin
            m_word = exp_word;
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_wdata", bus.mem_wdata, exp_word);
            chk("in_ready_write", 32'(bus.in_ready), 32'd0);
        end
    endtask

    // Hold mem_ready low for 'stall' cycles, then complete the write.
    task automatic complete(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_mem_we", 32'(bus.mem_we), 32'd1);
            chk("stall_mem_addr", bus.mem_addr, m_addr);
            chk("stall_mem_wdata", bus.mem_wdata, m_word);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        m_addr = m_addr + 32'd4;
        chk("we_drop", 32'(bus.mem_we), 32'd0);
        chk("in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("addr_incr", bus.mem_addr, m_addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rej;
        logic [31:0] word;
        logic [1:0]  fmt;
        logic [31:0] imm;
        int          bnd [10];
        bnd = '{-4097, -4096, -2049, -2048, 2047, 2048, 4093, 4094, 4095, 4096};

        tbl[0] = '{2'b00, 3'd0, 5'd1,  5'd0,  5'd0, 32'd5,          1'b0, 32'h0050_0093};
        tbl[1] = '{2'b01, 3'd2, 5'd0,  5'd1,  5'd2, 32'hFFFF_FFFC,  1'b0, 32'hFE20_AE23};
        tbl[2] = '{2'b10, 3'd0, 5'd0,  5'd1,  5'd2, 32'hFFFF_FFF8,  1'b0, 32'hFE20_8CE3};
`ifdef IMM_RANGE_CHECK_EN
        tbl[3] = '{2'b00, 3'd0, 5'd1,  5'd0,  5'd0, 32'd2048,       1'b1, 32'h0};
        tbl[4] = '{2'b10, 3'd0, 5'd0,  5'd1,  5'd2, 32'd3,          1'b1, 32'h0};
`else
        tbl[3] = '{2'b00, 3'd0, 5'd1,  5'd0,  5'd0, 32'd2048,       1'b0, 32'h8000_0093};
        tbl[4] = '{2'b10, 3'd0, 5'd0,  5'd1,  5'd2, 32'd3,          1'b0, 32'h0020_8163};
`endif
        tbl[5] = '{2'b11, 3'd0, 5'd0,  5'd0,  5'd0, 32'd0,          1'b1, 32'h0};
        tbl[6] = '{2'b00, 3'd0, 5'd1,  5'd0,  5'd0, 32'hFFFF_F800,  1'b0, 32'h8000_0093};
        tbl[7] = '{2'b10, 3'd0, 5'd0,  5'd0,  5'd0, 32'd4094,       1'b0, 32'h7E00_0FE3};
        tbl[8] = '{2'b10, 3'd0, 5'd0,  5'd0,  5'd0, 32'hFFFF_F000,  1'b0, 32'h8000_0063};
        tbl[9] = '{2'b00, 3'd7, 5'd31, 5'd31, 5'd0, 32'd2047,       1'b0, 32'h7FFF_FF93};

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_funct3 = '0; bus.in_rd = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, BASE);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        m_addr   = BASE;
        m_errcnt = 0;

        // Directed vectors; first two valid writes land at 0xFFFF_FFFC then wrap to 0.
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].fmt, tbl[i].f3, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                  tbl[i].rej, tbl[i].word);
            if (!tbl[i].rej) complete(i % 4);
        end

        // Randomized bundles, biased toward immediate boundaries.
        for (int i = 0; i < 60; i++) begin
            fmt = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       imm = $urandom;
                default: imm = 32'(bnd[$urandom_range(0, 9)]);
            endcase
            ref_encode(fmt, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, rej, word);
            issue(fmt, word[14:12], word[11:7], word[19:15], word[24:20], imm, rej, word);
            if (!rej) complete($urandom_range(0, 3));
        end

        // Saturate the error counter.
        for (int i = 0; i < 260; i++)
            issue(2'b11, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0);
        chk("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);

        // Flush in WRITE with simultaneous mem_ready: flush wins.
        issue(2'b00, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        m_addr = BASE;
        chk("flush_mem_we", 32'(bus.mem_we), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_mem_addr", bus.mem_addr, BASE);
        chk("flush_err_cnt_kept", 32'(bus.err_cnt), 32'd255);
        issue(2'b01, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'hFE20_AE23);
        complete(1);

        // Flush in ENCODE of a bundle that would be rejected: no err pulse.
        bus.in_fmt = 2'b11;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        m_addr = BASE;
        chk("flush_enc_err", 32'(bus.err), 32'd0);
        chk("flush_enc_mem_we", 32'(bus.mem_we), 32'd0);
        chk("flush_enc_addr", bus.mem_addr, BASE);
        chk("flush_enc_in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-WRITE.
        issue(2'b10, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0, 32'hFE20_8CE3);
        reset = 1'b1;
        #1;
        chk("arst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("arst_mem_addr", bus.mem_addr, BASE);
        @(posedge clk); #1;
        reset = 1'b0;
        m_addr = BASE;
        m_errcnt = 0;
        @(posedge clk); #1;
        chk("arst_in_ready_after", 32'(bus.in_ready), 32'd1);
        issue(2'b00, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
        complete(0);
        issue(2'b11, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
